// File: rtl/playseq_pkg.sv
// Shared definitions for the PlaySeq preview sequencer: state encodings,
// default timing constants and the debug state code.
package playseq_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    CARREGA = 3'd2,
    ACESO   = 3'd3,
    APAGADO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int T_ON_LENTO_DEF  = 1000;
  localparam int T_ON_RAPIDO_DEF = 500;
  localparam int T_OFF_DEF       = 250;

  function automatic logic [2:0] codigo_db(input estado_t e);
    return 3'(e);
  endfunction

endpackage

// File: rtl/playseq_temporizador.sv
// Up-counting phase timer: cleared by zera, advanced by conta, and flags
// when the count equals a limit supplied at run time.
module playseq_temporizador
  import playseq_pkg::*;
#(
  parameter int TMR_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             conta,
  input  logic [TMR_W-1:0] limite_tc,
  output logic             fim_tc
);

  logic [TMR_W-1:0] valor;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      valor <= '0;
    else if (zera)
      valor <= '0;
    else if (conta)
      valor <= valor + TMR_W'(1);
  end

  assign fim_tc = (valor == limite_tc);

endmodule

// File: rtl/playseq_preview_ctrl.sv
// PlaySeq LED preview sequencer: walks the sequence RAM from 0 to a latched
// last address, showing each word for an ON time and then a blank gap.
// states: OCIOSO idle | BUSCA addr settles | CARREGA latch word | ACESO leds on | APAGADO gap | FIM done pulse
module playseq_preview_ctrl
  import playseq_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int TMR_W       = 12,
  parameter int T_ON_LENTO  = T_ON_LENTO_DEF,
  parameter int T_ON_RAPIDO = T_ON_RAPIDO_DEF,
  parameter int T_OFF       = T_OFF_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              nivel_rapido,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] ram_dado,
  output logic [ADDR_W-1:0] ram_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  if (T_ON_LENTO < 1 || T_ON_LENTO >= 2**TMR_W ||
      T_ON_RAPIDO < 1 || T_ON_RAPIDO >= 2**TMR_W ||
      T_OFF < 1 || T_OFF >= 2**TMR_W) begin : g_chk_tempos
    $error("playseq_preview_ctrl: timing constants must be >=1 and fit in TMR_W bits");
  end

  localparam logic [TMR_W-1:0] TC_LENTO  = TMR_W'(T_ON_LENTO - 1);
  localparam logic [TMR_W-1:0] TC_RAPIDO = TMR_W'(T_ON_RAPIDO - 1);
  localparam logic [TMR_W-1:0] TC_OFF    = TMR_W'(T_OFF - 1);

  estado_t           estado, prox;
  logic [ADDR_W-1:0] endereco, limite_reg;
  logic [DATA_W-1:0] leds_reg;
  logic              rapido_reg;
  logic [TMR_W-1:0]  limite_tc;
  logic              zera_tmr, conta_tmr, fim_tc;
  logic              inicia, carrega, avanca, limpa;

  playseq_temporizador #(.TMR_W(TMR_W)) u_temporizador (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera_tmr),
    .conta     (conta_tmr),
    .limite_tc (limite_tc),
    .fim_tc    (fim_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= OCIOSO;
    else
      estado <= prox;
  end

  always_comb begin
    prox      = estado;
    zera_tmr  = 1'b0;
    conta_tmr = 1'b0;
    inicia    = 1'b0;
    carrega   = 1'b0;
    avanca    = 1'b0;
    limpa     = 1'b0;
    limite_tc = TC_OFF;
    if (estado == ACESO)
      limite_tc = rapido_reg ? TC_RAPIDO : TC_LENTO;

    // abort outranks every transition, FIM->OCIOSO included
    if (abort && estado != OCIOSO) begin
      prox     = OCIOSO;
      zera_tmr = 1'b1;
      limpa    = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          if (start && !abort) begin
            prox   = BUSCA;
            inicia = 1'b1;
          end
        end
        BUSCA:   prox = CARREGA;
        CARREGA: begin
          carrega  = 1'b1;
          zera_tmr = 1'b1;
          prox     = ACESO;
        end
        ACESO: begin
          if (fim_tc) begin
            zera_tmr = 1'b1;
            prox     = APAGADO;
          end else begin
            conta_tmr = 1'b1;
          end
        end
        APAGADO: begin
          if (fim_tc) begin
            zera_tmr = 1'b1;
            // compare before increment so the last address never wraps
            if (endereco == limite_reg) begin
              prox = FIM;
            end else begin
              avanca = 1'b1;
              prox   = BUSCA;
            end
          end else begin
            conta_tmr = 1'b1;
          end
        end
        FIM:     prox = OCIOSO;
        default: prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      limite_reg <= '0;
      rapido_reg <= 1'b0;
      leds_reg   <= '0;
    end else begin
      if (inicia) begin
        endereco   <= '0;
        limite_reg <= limite;
        rapido_reg <= nivel_rapido;
      end
      if (avanca)
        endereco <= endereco + ADDR_W'(1);
      if (carrega)
        leds_reg <= ram_dado;
      if (limpa)
        leds_reg <= '0;
    end
  end

  assign leds         = (estado == ACESO) ? leds_reg : '0;
  assign ocupado      = (estado != OCIOSO);
  assign pronto       = (estado == FIM);
  assign ram_endereco = endereco;
  assign db_estado    = codigo_db(estado);

endmodule

// File: tb/tb_playseq_preview_ctrl.sv
// Directed bench for playseq_preview_ctrl with short timing (ON 4/2, OFF 2)
// and a four-word one-hot sequence RAM.
module tb_playseq_preview_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic       nivel_rapido;
  logic [3:0] limite;
  logic [3:0] ram_dado;
  logic [3:0] ram_endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  playseq_preview_ctrl #(
    .ADDR_W      (4),
    .DATA_W      (4),
    .TMR_W       (12),
    .T_ON_LENTO  (4),
    .T_ON_RAPIDO (2),
    .T_OFF       (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .nivel_rapido (nivel_rapido),
    .limite       (limite),
    .ram_dado     (ram_dado),
    .ram_endereco (ram_endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  assign ram_dado = mem[ram_endereco];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_leds;
    int         idx;

    for (int i = 0; i < 16; i++) mem[i] = 4'b0000;
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;

    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    nivel_rapido = 1'b0;
    limite       = 4'd0;
    #12 reset = 1'b0;
    #1;
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_endereco", 32'(ram_endereco), 32'd0);
    check("rst_db", 32'(db_estado), 32'd0);

    // slow preview, limite=2, P=8
    limite = 4'd2;
    nivel_rapido = 1'b0;
    pulse_start();
    check("lento_db_e0", 32'(db_estado), 32'd1);
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_leds = (k >= 2  && k <= 5)  ? 4'b0001 :
                 (k >= 10 && k <= 13) ? 4'b0010 :
                 (k >= 18 && k <= 21) ? 4'b0100 : 4'b0000;
      check($sformatf("lento_leds_e%0d", k), 32'(leds), 32'(exp_leds));
      check($sformatf("lento_pronto_e%0d", k), 32'(pronto), 32'(k == 24));
      check($sformatf("lento_ocupado_e%0d", k), 32'(ocupado), 32'(k <= 24));
      if (k == 1) check("lento_db_carrega", 32'(db_estado), 32'd2);
      if (k == 2) check("lento_db_aceso", 32'(db_estado), 32'd3);
      if (k == 6) check("lento_db_apagado", 32'(db_estado), 32'd4);
      if (k == 24) check("lento_db_fim", 32'(db_estado), 32'd5);
    end

    // fast preview, limite=3, P=6
    limite = 4'd3;
    nivel_rapido = 1'b1;
    pulse_start();
    nivel_rapido = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      idx = k / 6;
      exp_leds = (k < 24 && (k % 6 == 2 || k % 6 == 3)) ? 4'(1 << idx) : 4'b0000;
      check($sformatf("rapido_leds_e%0d", k), 32'(leds), 32'(exp_leds));
      check($sformatf("rapido_pronto_e%0d", k), 32'(pronto), 32'(k == 24));
      check($sformatf("rapido_end_e%0d", k), 32'(ram_endereco), 32'((idx > 3) ? 3 : idx));
    end

    // limite=0 with limite changed mid-preview
    limite = 4'd0;
    pulse_start();
    limite = 4'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_leds = (k >= 2 && k <= 5) ? 4'b0001 : 4'b0000;
      check($sformatf("lim0_leds_e%0d", k), 32'(leds), 32'(exp_leds));
      check($sformatf("lim0_pronto_e%0d", k), 32'(pronto), 32'(k == 8));
      check($sformatf("lim0_ocupado_e%0d", k), 32'(ocupado), 32'(k <= 8));
    end

    // start during APAGADO (edge 7) must not disturb timing
    limite = 4'd0;
    pulse_start();
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("startign_pronto_e%0d", k), 32'(pronto), 32'(k == 8));
      check($sformatf("startign_ocupado_e%0d", k), 32'(ocupado), 32'(k <= 8));
      start = (k == 6);
    end
    start = 1'b0;

    // abort during ACESO of entry 1
    limite = 4'd3;
    pulse_start();
    for (int k = 1; k <= 11; k++) tick();
    check("abort_pre_leds", 32'(leds), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_db", 32'(db_estado), 32'd0);
    check("abort_leds", 32'(leds), 32'd0);
    check("abort_ocupado", 32'(ocupado), 32'd0);
    check("abort_pronto", 32'(pronto), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_sem_pronto", 32'(pronto), 32'd0);
      check("abort_idle", 32'(ocupado), 32'd0);
    end
    pulse_start();
    check("restart_end", 32'(ram_endereco), 32'd0);
    check("restart_db", 32'(db_estado), 32'd1);
    tick();
    tick();
    check("restart_leds", 32'(leds), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("restart_abort_db", 32'(db_estado), 32'd0);

    // start and abort together while idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("startabort_ocupado", 32'(ocupado), 32'd0);
    check("startabort_db", 32'(db_estado), 32'd0);
    tick();
    check("startabort_ocupado2", 32'(ocupado), 32'd0);

    // asynchronous reset in the middle of ACESO
    limite = 4'd0;
    pulse_start();
    tick();
    tick();
    tick();
    check("rstmid_pre_leds", 32'(leds), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_leds", 32'(leds), 32'd0);
    check("rstmid_db", 32'(db_estado), 32'd0);
    check("rstmid_ocupado", 32'(ocupado), 32'd0);
    #2 reset = 1'b0;
    tick();
    check("rstmid_after_db", 32'(db_estado), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
